// File: rtl/calc_sequencer_if.sv
// Keypad and ALU connections of the calculator sequencer, grouped for port reuse.
// key_rdy holds a decoded key until release; key_rd pulses once per accepted key.
// alu_start launches with alu_a/alu_b/alu_op stable until alu_done pulses with the result.
interface calc_sequencer_if;
  logic        key_rdy;
  logic        key_rd;
  logic [3:0]  keypad_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_ovf;
  logic [15:0] display_val;
  logic        error;

  modport master (
    input  key_rdy, keypad_input, operator_input, equal_input,
    input  alu_done, alu_result, alu_ovf,
    output key_rd, alu_a, alu_b, alu_op, alu_start, display_val, error
  );

  modport slave (
    output key_rdy, keypad_input, operator_input, equal_input,
    output alu_done, alu_result, alu_ovf,
    input  key_rd, alu_a, alu_b, alu_op, alu_start, display_val, error
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: collects keypad operands and operators, launches the external
// ALU, and tracks the displayed value and error state.
module calc_sequencer (
  input  logic             clk,
  input  logic             nRST,
  calc_sequencer_if.master bus,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {
    ST_ENTER_A  = 3'd0,
    ST_ENTER_B  = 3'd1,
    ST_WAIT_ALU = 3'd2,
    ST_SHOW     = 3'd3,
    ST_ERR      = 3'd4
  } state_t;

  localparam logic [2:0]  OP_NEG  = 3'b001;
  localparam logic [2:0]  OP_ADD  = 3'b010;
  localparam logic [2:0]  OP_SUB  = 3'b011;
  localparam logic [2:0]  OP_MUL  = 3'b100;
  localparam logic [15:0] MIN_NEG = 16'h8000;

  state_t      state_q, state_d;
  logic [14:0] a_mag_q, a_mag_d;
  logic [14:0] b_mag_q, b_mag_d;
  logic        a_sign_q, a_sign_d;
  logic        b_sign_q, b_sign_d;
  logic        b_entered_q, b_entered_d;
  logic        armed_q, armed_d;
  logic [15:0] result_q, result_d;
  logic [7:0]  wdog_q, wdog_d;
  logic        key_rd_q, key_rd_d;
  logic        alu_start_q, alu_start_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic [15:0] display_q, display_d;
  logic        error_q, error_d;

  logic        accept;
  logic        key_equal, key_neg, key_arith, key_digit;
  logic [3:0]  digit;
  logic [15:0] neg_result;
  logic [14:0] result_abs;
  logic [15:0] a_val_d, b_val_d;

  function automatic logic [14:0] digit_step(input logic [14:0] mag, input logic [3:0] d);
    logic [18:0] t;
    t = {4'd0, mag} * 19'd10 + {15'd0, d};
    return (t <= 19'd32767) ? t[14:0] : mag;
  endfunction

  function automatic logic [15:0] operand(input logic [14:0] mag, input logic sign);
    logic [15:0] v;
    v = {1'b0, mag};
    return sign ? (16'd0 - v) : v;
  endfunction

  // A key is taken once per press: armed re-arms only after key_rdy is seen low.
  assign accept    = bus.key_rdy && armed_q && (state_q != ST_WAIT_ALU);
  assign key_equal = bus.equal_input;
  assign key_neg   = !bus.equal_input && (bus.operator_input == OP_NEG);
  assign key_arith = !bus.equal_input && ((bus.operator_input == OP_ADD) ||
                     (bus.operator_input == OP_SUB) || (bus.operator_input == OP_MUL));
  assign key_digit = !bus.equal_input && (bus.operator_input == 3'b000);
  assign digit     = (bus.keypad_input <= 4'd9) ? bus.keypad_input : 4'd0;

  // |result| is also |-result|; the one unrepresentable value (MIN_NEG) is routed to ERR.
  assign neg_result = 16'd0 - result_q;
  assign result_abs = result_q[15] ? neg_result[14:0] : result_q[14:0];

  always_comb begin
    state_d     = state_q;
    a_mag_d     = a_mag_q;
    b_mag_d     = b_mag_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    b_entered_d = b_entered_q;
    result_d    = result_q;
    wdog_d      = wdog_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = 1'b0;
    key_rd_d    = accept;
    armed_d     = accept ? 1'b0 : (!bus.key_rdy ? 1'b1 : armed_q);

    case (state_q)
      ST_ENTER_A: begin
        if (accept) begin
          if (key_digit) begin
            a_mag_d = digit_step(a_mag_q, digit);
          end else if (key_neg) begin
            a_sign_d = !a_sign_q;
          end else if (key_arith) begin
            alu_op_d    = bus.operator_input;
            b_mag_d     = 15'd0;
            b_sign_d    = 1'b0;
            b_entered_d = 1'b0;
            state_d     = ST_ENTER_B;
          end
        end
      end
      ST_ENTER_B: begin
        if (accept) begin
          if (key_equal) begin
            if (b_entered_q) begin
              alu_a_d     = operand(a_mag_q, a_sign_q);
              alu_b_d     = operand(b_mag_q, b_sign_q);
              alu_start_d = 1'b1;
              wdog_d      = 8'd0;
              state_d     = ST_WAIT_ALU;
            end
          end else if (key_digit) begin
            b_mag_d     = digit_step(b_mag_q, digit);
            b_entered_d = 1'b1;
          end else if (key_neg) begin
            b_sign_d = !b_sign_q;
          end else if (key_arith && !b_entered_q) begin
            alu_op_d = bus.operator_input;
          end
        end
      end
      ST_WAIT_ALU: begin
        wdog_d = wdog_q + 8'd1;
        if (bus.alu_done) begin
          if (bus.alu_ovf) begin
            state_d = ST_ERR;
          end else begin
            result_d = bus.alu_result;
            state_d  = ST_SHOW;
          end
        end else if (wdog_q == 8'hFF) begin
          state_d = ST_ERR;
        end
      end
      ST_SHOW: begin
        if (accept) begin
          if (key_digit) begin
            a_mag_d     = {11'd0, digit};
            a_sign_d    = 1'b0;
            b_mag_d     = 15'd0;
            b_sign_d    = 1'b0;
            b_entered_d = 1'b0;
            state_d     = ST_ENTER_A;
          end else if (key_arith || key_neg) begin
            if (result_q == MIN_NEG) begin
              state_d = ST_ERR;
            end else if (key_neg) begin
              a_mag_d  = result_abs;
              a_sign_d = neg_result[15];
              state_d  = ST_ENTER_A;
            end else begin
              a_mag_d     = result_abs;
              a_sign_d    = result_q[15];
              alu_op_d    = bus.operator_input;
              b_mag_d     = 15'd0;
              b_sign_d    = 1'b0;
              b_entered_d = 1'b0;
              state_d     = ST_ENTER_B;
            end
          end
        end
      end
      ST_ERR: begin
        if (accept && key_equal) begin
          a_mag_d     = 15'd0;
          a_sign_d    = 1'b0;
          b_mag_d     = 15'd0;
          b_sign_d    = 1'b0;
          b_entered_d = 1'b0;
          result_d    = 16'd0;
          state_d     = ST_ENTER_A;
        end
      end
      default: state_d = ST_ENTER_A;
    endcase

    a_val_d = operand(a_mag_d, a_sign_d);
    b_val_d = operand(b_mag_d, b_sign_d);
    case (state_d)
      ST_ENTER_A:  display_d = a_val_d;
      ST_ENTER_B:  display_d = b_entered_d ? b_val_d : a_val_d;
      ST_WAIT_ALU: display_d = a_val_d;
      ST_SHOW:     display_d = result_d;
      default:     display_d = 16'd0;
    endcase
    error_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_ENTER_A;
      a_mag_q     <= 15'd0;
      b_mag_q     <= 15'd0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      b_entered_q <= 1'b0;
      armed_q     <= 1'b0;
      result_q    <= 16'd0;
      wdog_q      <= 8'd0;
      key_rd_q    <= 1'b0;
      alu_start_q <= 1'b0;
      alu_a_q     <= 16'd0;
      alu_b_q     <= 16'd0;
      alu_op_q    <= 3'b000;
      display_q   <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_mag_q     <= a_mag_d;
      b_mag_q     <= b_mag_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      b_entered_q <= b_entered_d;
      armed_q     <= armed_d;
      result_q    <= result_d;
      wdog_q      <= wdog_d;
      key_rd_q    <= key_rd_d;
      alu_start_q <= alu_start_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      display_q   <= display_d;
      error_q     <= error_d;
    end
  end

  assign bus.key_rd      = key_rd_q;
  assign bus.alu_start   = alu_start_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.display_val = display_q;
  assign bus.error       = error_q;
  assign dbg_state       = state_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random key streams checked
// against a value-level calculator model.
module tb_calc_sequencer;
  logic       clk = 1'b0;
  logic       nRST = 1'b0;
  logic [2:0] dbg_state;

  calc_sequencer_if bus ();
  calc_sequencer dut (.clk(clk), .nRST(nRST), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_count = 0;
  int start_count = 0;
  logic [15:0] cap_a, cap_b;
  logic [2:0]  cap_op;
  logic [15:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.key_rd === 1'b1) rd_count++;
    if (bus.alu_start === 1'b1) begin
      start_count++;
      cap_a  = bus.alu_a;
      cap_b  = bus.alu_b;
      cap_op = bus.alu_op;
    end
  end

  // Model state: 0 enter_a, 1 enter_b, 2 wait_alu, 3 show, 4 err
  int m_st, m_a_mag, m_b_mag, m_res;
  bit m_a_neg, m_b_neg, m_b_ent;
  int m_op;

  function automatic int sval(input int mag, input bit neg);
    return neg ? -mag : mag;
  endfunction

  function automatic int add_digit(input int mag, input int d);
    return (mag * 10 + d <= 32767) ? mag * 10 + d : mag;
  endfunction

  function automatic int m_disp();
    case (m_st)
      0: return sval(m_a_mag, m_a_neg);
      1: return m_b_ent ? sval(m_b_mag, m_b_neg) : sval(m_a_mag, m_a_neg);
      2: return sval(m_a_mag, m_a_neg);
      3: return m_res;
      default: return 0;
    endcase
  endfunction

  task automatic m_clear();
    m_st = 0; m_a_mag = 0; m_b_mag = 0; m_res = 0;
    m_a_neg = 0; m_b_neg = 0; m_b_ent = 0; m_op = 0;
  endtask

  task automatic m_set_a(input int v);
    m_a_neg = (v < 0);
    m_a_mag = (v < 0) ? -v : v;
  endtask

  task automatic model_key(input int d, input int op, input bit eq);
    bit is_dig, is_neg, is_ar;
    is_dig = !eq && op == 0;
    is_neg = !eq && op == 1;
    is_ar  = !eq && op >= 2 && op <= 4;
    case (m_st)
      0: begin
        if (is_dig) m_a_mag = add_digit(m_a_mag, d);
        else if (is_neg) m_a_neg = !m_a_neg;
        else if (is_ar) begin
          m_op = op; m_b_mag = 0; m_b_neg = 0; m_b_ent = 0; m_st = 1;
        end
      end
      1: begin
        if (eq) begin
          if (m_b_ent) begin
            exp_q.push_back(16'(sval(m_a_mag, m_a_neg)));
            exp_q.push_back(16'(sval(m_b_mag, m_b_neg)));
            m_st = 2;
          end
        end else if (is_dig) begin
          m_b_mag = add_digit(m_b_mag, d); m_b_ent = 1;
        end else if (is_neg) m_b_neg = !m_b_neg;
        else if (is_ar && !m_b_ent) m_op = op;
      end
      3: begin
        if (is_dig) begin
          m_a_mag = d; m_a_neg = 0; m_b_mag = 0; m_b_neg = 0; m_b_ent = 0; m_st = 0;
        end else if ((is_ar || is_neg) && m_res == -32768) m_st = 4;
        else if (is_neg) begin
          m_set_a(-m_res); m_st = 0;
        end else if (is_ar) begin
          m_set_a(m_res); m_op = op; m_b_mag = 0; m_b_neg = 0; m_b_ent = 0; m_st = 1;
        end
      end
      4: if (eq) m_clear();
      default: ;
    endcase
  endtask

  task automatic reset_dut();
    nRST = 1'b0;
    bus.key_rdy = 1'b0; bus.keypad_input = 4'd0; bus.operator_input = 3'd0;
    bus.equal_input = 1'b0; bus.alu_done = 1'b0; bus.alu_result = 16'd0; bus.alu_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 nRST = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    m_clear();
    exp_q.delete();
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] op, input logic eq);
    int n;
    bus.keypad_input = d; bus.operator_input = op; bus.equal_input = eq;
    bus.key_rdy = 1'b1;
    n = 0;
    while (bus.key_rd !== 1'b1 && n < 8) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.key_rd !== 1'b1) begin
      errors++; $display("FAIL key_ack: key_rd=%b required 1", bus.key_rd);
    end
    bus.key_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic alu_finish(input logic [15:0] r, input logic ovf, input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    checks++;
    if (bus.alu_a !== cap_a || bus.alu_b !== cap_b || bus.alu_op !== cap_op) begin
      errors++;
      $display("FAIL alu_stable: a=%h b=%h op=%b required a=%h b=%h op=%b",
               bus.alu_a, bus.alu_b, bus.alu_op, cap_a, cap_b, cap_op);
    end
    bus.alu_done = 1'b1; bus.alu_result = r; bus.alu_ovf = ovf;
    @(posedge clk); #1;
    bus.alu_done = 1'b0; bus.alu_ovf = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (bus.display_val !== 16'd0 || bus.error !== 1'b0 || bus.key_rd !== 1'b0 ||
        bus.alu_start !== 1'b0 || bus.alu_a !== 16'd0 || bus.alu_b !== 16'd0 ||
        bus.alu_op !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: disp=%h err=%b rd=%b start=%b a=%h b=%h op=%b required all 0",
               bus.display_val, bus.error, bus.key_rd, bus.alu_start, bus.alu_a, bus.alu_b, bus.alu_op);
    end
  endtask

  task automatic test_add();
    int s0;
    reset_dut();
    s0 = start_count;
    press(4'd1, 3'd0, 1'b0); press(4'd2, 3'd0, 1'b0);
    press(4'd0, 3'b010, 1'b0); press(4'd5, 3'd0, 1'b0);
    press(4'd0, 3'd0, 1'b1);
    checks++;
    if (start_count != s0 + 1 || cap_a !== 16'd12 || cap_b !== 16'd5 || cap_op !== 3'b010) begin
      errors++;
      $display("FAIL add_launch: starts=%0d a=%0d b=%0d op=%b required starts=1 a=12 b=5 op=010",
               start_count - s0, cap_a, cap_b, cap_op);
    end
    alu_finish(16'd17, 1'b0, 2);
    checks++;
    if (bus.display_val !== 16'd17 || bus.error !== 1'b0) begin
      errors++; $display("FAIL add_result: disp=%0d err=%b required 17 0", bus.display_val, bus.error);
    end
    press(4'd4, 3'd0, 1'b0);
    checks++;
    if (bus.display_val !== 16'd4) begin
      errors++; $display("FAIL show_digit: disp=%0d required 4", bus.display_val);
    end
  endtask

  task automatic test_digit_limit();
    int r0;
    reset_dut();
    r0 = rd_count;
    press(4'd3, 3'd0, 1'b0); press(4'd2, 3'd0, 1'b0);
    press(4'd7, 3'd0, 1'b0); press(4'd6, 3'd0, 1'b0);
    checks++;
    if (bus.display_val !== 16'd3276) begin
      errors++; $display("FAIL digits_4: disp=%0d required 3276", bus.display_val);
    end
    press(4'd8, 3'd0, 1'b0);
    checks++;
    if (bus.display_val !== 16'd3276) begin
      errors++; $display("FAIL digit_overflow: disp=%0d required 3276", bus.display_val);
    end
    checks++;
    if (rd_count - r0 != 5) begin
      errors++; $display("FAIL digit_acks: pulses=%0d required 5", rd_count - r0);
    end
    reset_dut();
    press(4'd5, 3'd0, 1'b0); press(4'hB, 3'd0, 1'b0);
    checks++;
    if (bus.display_val !== 16'd50) begin
      errors++; $display("FAIL hash_digit: disp=%0d required 50", bus.display_val);
    end
  endtask

  task automatic test_held_key();
    int r0;
    reset_dut();
    r0 = rd_count;
    bus.keypad_input = 4'd9; bus.operator_input = 3'd0; bus.equal_input = 1'b0;
    bus.key_rdy = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    checks++;
    if (rd_count - r0 != 1) begin
      errors++; $display("FAIL held_key: pulses=%0d required 1", rd_count - r0);
    end
    bus.key_rdy = 1'b0;
    @(posedge clk); #1;
    bus.keypad_input = 4'd1; bus.key_rdy = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    bus.key_rdy = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rd_count - r0 != 2 || bus.display_val !== 16'd91) begin
      errors++;
      $display("FAIL second_key: pulses=%0d disp=%0d required 2 91", rd_count - r0, bus.display_val);
    end
  endtask

  task automatic test_watchdog();
    int n;
    reset_dut();
    press(4'd4, 3'd0, 1'b0); press(4'd0, 3'b010, 1'b0);
    press(4'd6, 3'd0, 1'b0); press(4'd0, 3'd0, 1'b1);
    n = 0;
    while (bus.error !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
    checks++;
    if (bus.error !== 1'b1 || n < 250 || n > 260 || bus.display_val !== 16'd0) begin
      errors++;
      $display("FAIL watchdog: err=%b cycles=%0d disp=%0d required 1 250..260 0",
               bus.error, n, bus.display_val);
    end
    press(4'd0, 3'd0, 1'b1);
    checks++;
    if (bus.error !== 1'b0 || bus.display_val !== 16'd0) begin
      errors++; $display("FAIL err_clear: err=%b disp=%0d required 0 0", bus.error, bus.display_val);
    end
    press(4'd2, 3'd0, 1'b0);
    checks++;
    if (bus.display_val !== 16'd2) begin
      errors++; $display("FAIL after_clear: disp=%0d required 2", bus.display_val);
    end
  endtask

  task automatic test_neg_mul();
    reset_dut();
    press(4'd7, 3'd0, 1'b0); press(4'd0, 3'b001, 1'b0);
    press(4'd0, 3'b100, 1'b0); press(4'd3, 3'd0, 1'b0);
    press(4'd0, 3'd0, 1'b1);
    checks++;
    if (cap_a !== 16'hFFF9 || cap_b !== 16'd3 || cap_op !== 3'b100) begin
      errors++;
      $display("FAIL neg_mul_launch: a=%h b=%h op=%b required fff9 0003 100", cap_a, cap_b, cap_op);
    end
    alu_finish(16'hFFEB, 1'b0, 1);
    checks++;
    if (bus.display_val !== 16'hFFEB) begin
      errors++; $display("FAIL neg_mul_result: disp=%h required ffeb", bus.display_val);
    end
    press(4'd0, 3'b011, 1'b0); press(4'd1, 3'd0, 1'b0);
    press(4'd0, 3'd0, 1'b1);
    checks++;
    if (cap_a !== 16'hFFEB || cap_b !== 16'd1 || cap_op !== 3'b011) begin
      errors++;
      $display("FAIL chain_launch: a=%h b=%h op=%b required ffeb 0001 011", cap_a, cap_b, cap_op);
    end
    alu_finish(16'hFFEA, 1'b0, 0);
  endtask

  task automatic test_err_paths();
    reset_dut();
    press(4'd1, 3'd0, 1'b0); press(4'd0, 3'b010, 1'b0);
    press(4'd1, 3'd0, 1'b0); press(4'd0, 3'd0, 1'b1);
    alu_finish(16'h8000, 1'b0, 0);
    checks++;
    if (bus.display_val !== 16'h8000 || bus.error !== 1'b0) begin
      errors++; $display("FAIL min_show: disp=%h err=%b required 8000 0", bus.display_val, bus.error);
    end
    press(4'd0, 3'b001, 1'b0);
    checks++;
    if (bus.error !== 1'b1 || bus.display_val !== 16'd0) begin
      errors++; $display("FAIL min_neg: err=%b disp=%h required 1 0", bus.error, bus.display_val);
    end
    press(4'd0, 3'd0, 1'b1);
    press(4'd2, 3'd0, 1'b0); press(4'd0, 3'b100, 1'b0);
    press(4'd3, 3'd0, 1'b0); press(4'd0, 3'd0, 1'b1);
    alu_finish(16'd6, 1'b1, 3);
    checks++;
    if (bus.error !== 1'b1 || bus.display_val !== 16'd0) begin
      errors++; $display("FAIL alu_ovf: err=%b disp=%h required 1 0", bus.error, bus.display_val);
    end
  endtask

  task automatic test_reset_in_wait();
    int s0, r0;
    reset_dut();
    press(4'd5, 3'd0, 1'b0); press(4'd0, 3'b010, 1'b0);
    press(4'd5, 3'd0, 1'b0); press(4'd0, 3'd0, 1'b1);
    @(posedge clk); #1;
    nRST = 1'b0;
    #2;
    checks++;
    if (bus.display_val !== 16'd0 || bus.error !== 1'b0 || bus.alu_a !== 16'd0 ||
        bus.alu_b !== 16'd0 || bus.alu_op !== 3'd0 || bus.alu_start !== 1'b0 || bus.key_rd !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: disp=%h err=%b a=%h b=%h op=%b required all 0",
               bus.display_val, bus.error, bus.alu_a, bus.alu_b, bus.alu_op);
    end
    bus.keypad_input = 4'd7; bus.operator_input = 3'd0; bus.equal_input = 1'b0;
    bus.key_rdy = 1'b1;
    @(posedge clk); #1;
    nRST = 1'b1;
    s0 = start_count; r0 = rd_count;
    bus.alu_done = 1'b1; bus.alu_result = 16'd10;
    @(posedge clk); #1;
    bus.alu_done = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    checks++;
    if (bus.display_val !== 16'd0 || bus.error !== 1'b0 || start_count != s0 || rd_count != r0) begin
      errors++;
      $display("FAIL stale_done: disp=%0d err=%b starts=%0d acks=%0d required 0 0 0 0",
               bus.display_val, bus.error, start_count - s0, rd_count - r0);
    end
    bus.key_rdy = 1'b0;
    @(posedge clk); #1;
    press(4'd0, 3'b010, 1'b0);
    checks++;
    if (bus.display_val !== 16'd0) begin
      errors++; $display("FAIL no_show_after_reset: disp=%0d required 0", bus.display_val);
    end
  endtask

  task automatic test_random();
    int d, op, s0, r0, a, b, r, pick;
    bit eq, ovf;
    logic [15:0] ea, eb;
    reset_dut();
    r0 = rd_count;
    for (int k = 0; k < 150; k++) begin
      pick = $urandom_range(0, 99);
      d = $urandom_range(0, 9); op = 0; eq = 0;
      if (pick >= 55 && pick < 63) op = 1;
      else if (pick >= 63 && pick < 80) op = $urandom_range(2, 4);
      else if (pick >= 80) eq = 1;
      s0 = start_count;
      press(4'(d), 3'(op), eq);
      model_key(d, op, eq);
      checks++;
      if (bus.display_val !== 16'(m_disp()) || bus.error !== (m_st == 4)) begin
        errors++;
        $display("FAIL rand_key%0d: disp=%h err=%b required %h %b",
                 k, bus.display_val, bus.error, 16'(m_disp()), (m_st == 4));
      end
      if (m_st == 2) begin
        ea = exp_q.pop_front(); eb = exp_q.pop_front();
        checks++;
        if (start_count != s0 + 1 || cap_a !== ea || cap_b !== eb || cap_op !== 3'(m_op)) begin
          errors++;
          $display("FAIL rand_launch%0d: starts=%0d a=%h b=%h op=%b required 1 %h %h %b",
                   k, start_count - s0, cap_a, cap_b, cap_op, ea, eb, 3'(m_op));
        end
        a = $signed(ea); b = $signed(eb);
        case (m_op)
          2: r = a + b;
          3: r = a - b;
          default: r = a * b;
        endcase
        ovf = (r > 32767) || (r < -32767);
        alu_finish(16'(r), ovf, $urandom_range(0, 4));
        if (ovf) m_st = 4;
        else begin m_res = r; m_st = 3; end
        checks++;
        if (bus.display_val !== 16'(m_disp()) || bus.error !== (m_st == 4)) begin
          errors++;
          $display("FAIL rand_result%0d: disp=%h err=%b required %h %b",
                   k, bus.display_val, bus.error, 16'(m_disp()), (m_st == 4));
        end
      end else begin
        checks++;
        if (start_count != s0) begin
          errors++; $display("FAIL rand_nostart%0d: starts=%0d required 0", k, start_count - s0);
        end
      end
    end
    checks++;
    if (rd_count - r0 != 150) begin
      errors++; $display("FAIL rand_acks: pulses=%0d required 150", rd_count - r0);
    end
  endtask

  initial begin
    bus.key_rdy = 1'b0; bus.keypad_input = 4'd0; bus.operator_input = 3'd0;
    bus.equal_input = 1'b0; bus.alu_done = 1'b0; bus.alu_result = 16'd0; bus.alu_ovf = 1'b0;
    test_reset();
    test_add();
    test_digit_limit();
    test_held_key();
    test_watchdog();
    test_neg_mul();
    test_err_paths();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 nRST  in  1  reset, asynchronous, active-low.
REQ-003 key_rdy  in  1  keypad block has a decoded key available; held high until that key is released.
REQ-004 key_rd  out  1  one-cycle acknowledge of an accepted key.
REQ-005 keypad_input  in  4  digit 0-9, valid while key_rdy=1.
REQ-006 operator_input  in  3  001 neg, 010 add, 011 sub, 100 mul, 000 none.
REQ-007 equal_input  in  1  equal key.
REQ-008 alu_a, alu_b  out  16 each  signed two's-complement operands to ALU.
REQ-009 alu_op  out  3  operation code to ALU (010/011/100).
REQ-010 alu_start  out  1  one-cycle ALU launch pulse.
REQ-011 alu_done  in  1  ALU result valid pulse.
REQ-012 alu_result  in  16  signed ALU result, sampled when alu_done=1.
REQ-013 alu_ovf  in  1  ALU overflow flag, sampled when alu_done=1.
REQ-014 display_val  out  16  signed value for display.
REQ-015 error  out  1  calculator error indicator.

Function
REQ-016 Key acceptance SHALL be edge-based: an internal armed flag is set when key_rdy=0 is sampled; a key is accepted in the cycle key_rdy=1 and armed=1 and the state accepts keys; key_rd=1 in the following cycle only; armed clears on acceptance.
REQ-017 A key SHALL be classified as equal if equal_input=1, else operator if operator_input!=000, else digit (a '#' key therefore enters digit 0).
REQ-018 States SHALL be ENTER_A, ENTER_B, WAIT_ALU, SHOW, ERR; only WAIT_ALU does not accept keys (key_rd held 0, armed preserved).
REQ-019 Operand entry SHALL hold a 15-bit magnitude and a sign bit; digit d updates mag to mag*10+d only if the result is <=32767, otherwise the digit is acknowledged and discarded.
REQ-020 Operand value SHALL be mag when sign=0, else -mag (range -32767..32767).
REQ-021 ENTER_A: digit -> update A; neg -> toggle A sign; add/sub/mul -> latch alu_op, clear B, go ENTER_B; equal -> no change.
REQ-022 ENTER_B: digit -> update B, set b_entered; neg -> toggle B sign; add/sub/mul -> replace alu_op if b_entered=0, else ignore; equal -> if b_entered=1 drive alu_a/alu_b, pulse alu_start one cycle, go WAIT_ALU; if b_entered=0 ignore.
REQ-023 alu_a, alu_b, alu_op SHALL remain stable from the alu_start cycle until alu_done is sampled.
REQ-024 WAIT_ALU: an 8-bit watchdog counts from 0 on entry; alu_done=1 with alu_ovf=0 -> latch result, go SHOW; alu_done=1 with alu_ovf=1 -> go ERR; counter reaching 255 without alu_done -> go ERR; alu_done in the same cycle the count hits 255 takes priority.
REQ-025 SHOW: digit -> clear A and B, A mag=digit, go ENTER_A; add/sub/mul -> A=result, latch op, go ENTER_B; neg -> A=-result, go ENTER_A, unless result=-32768 then go ERR; equal -> ignored.
REQ-026 ERR: error=1; equal -> clear all operands, error=0, go ENTER_A; other keys acknowledged and ignored.
REQ-027 display_val SHALL show A in ENTER_A, B in ENTER_B when b_entered=1 else A, A in WAIT_ALU, result in SHOW, 0 in ERR; updated the cycle after key acceptance (registered).
REQ-028 A key accepted in the same cycle as a state transition into WAIT_ALU is impossible; only one key is processed per acceptance.

Reset
REQ-029 On nRST=0: state ENTER_A, A=B=0, signs 0, b_entered=0, armed=0, result=0, watchdog=0; outputs key_rd=0, alu_start=0, alu_a=alu_b=0, alu_op=000, display_val=0, error=0.
REQ-030 Reset asserted in any state, including WAIT_ALU, SHALL abandon the operation; a later alu_done is ignored until the next alu_start.
REQ-031 armed=0 after reset, so a key held through reset release is not accepted until key_rdy drops.

Verification
REQ-032 Keys 1,2,A(010),5,equal; ALU returns 17 -> alu_start one cycle with alu_a=12, alu_b=5, alu_op=010; display_val=17, state SHOW.
REQ-033 Digits 3,2,7,6,8 -> display_val=3276 after the fourth digit, unchanged after the fifth; five key_rd pulses.
REQ-034 key_rdy held high 20 cycles -> exactly one key_rd pulse; second key after key_rdy low 1 cycle -> second pulse.
REQ-035 Equal in ENTER_B with alu_done withheld 255 cycles -> error=1, display_val=0; then equal -> error=0, display_val=0, ENTER_A.
REQ-036 7, neg, C(100), 3, equal; ALU returns -21 -> alu_a=-7 (0xFFF9), alu_b=3; then B(011), 1, equal -> alu_a=-21, alu_op=011.
REQ-037 nRST pulsed during WAIT_ALU, then alu_done asserted -> all outputs at reset values, display_val=0, no SHOW transition.
